// File: rtl/regfile_mp.sv
// Register file with NUM_RD asynchronous read ports, one synchronous write port and a post-reset clear sequencer.
// Optional write-first read forwarding is compiled in when REGFILE_BYPASS_EN is defined.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     ready,
  output logic                     wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    READY = 2'd1
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   idx, idx_nxt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      idx     <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      wr_drop <= wr_en && !ready;
    end
  end

  assign ready = (state == READY);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = idx[ADDR_W-1:0];
        mem_wdata = '0;
        idx_nxt   = idx + 1'b1;
        if (idx == LAST_IDX) state_nxt = READY;
      end
      READY: begin
        mem_we = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
      end
      default: state_nxt = CLEAR;
    endcase
    if (rst) mem_we = 1'b0;
  end

  // NOTE: the array has no reset; the clear sequencer defines its contents before ready rises.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] q;

    assign addr = rd_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      q = mem[addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (addr == wr_addr)) q = wr_data;
`endif
      if ((ZERO_REG != 0) && (addr == '0)) q = '0;
      if (!ready) q = '0;
    end

    assign rd_data[p*DATA_W +: DATA_W] = q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: two instances (zero register on/off) share stimulus and
// are compared against an array-based reference model after directed and random steps.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int RW    = NR * AW;
  localparam int DEPTH = 2 ** AW;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic [RW-1:0]  rd_addr;
  logic [NR*DW-1:0] rd_data_z, rd_data_nz;
  logic           ready_z, ready_nz, drop_z, drop_nz;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_z), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready_z), .wr_drop(drop_z)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nz), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready_nz), .wr_drop(drop_nz)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: contents per variant, readiness and clear progress.
  logic [DW-1:0] ref_z  [DEPTH];
  logic [DW-1:0] ref_nz [DEPTH];
  bit            ref_ready = 1'b0;
  bit            ref_drop  = 1'b0;
  int            clear_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input bit zero, input int a);
    if (!ref_ready) return '0;
    if (zero && a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && a == int'(wr_addr)) return wr_data;
`endif
    return zero ? ref_z[a] : ref_nz[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      ref_ready = 1'b0;
      ref_drop  = 1'b0;
      clear_cnt = 0;
    end else begin
      ref_drop = wr_en && !ref_ready;
      if (ref_ready) begin
        if (wr_en) begin
          if (wr_addr != 0) ref_z[wr_addr] = wr_data;
          ref_nz[wr_addr] = wr_data;
        end
      end else begin
        clear_cnt++;
        if (clear_cnt == DEPTH) begin
          ref_ready = 1'b1;
          for (int i = 0; i < DEPTH; i++) begin
            ref_z[i]  = '0;
            ref_nz[i] = '0;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string ctx);
    for (int p = 0; p < NR; p++) begin
      int a;
      a = int'(rd_addr[p*AW +: AW]);
      check($sformatf("%s rd%0d zreg a=%0d", ctx, p, a), 64'(rd_data_z[p*DW +: DW]), 64'(exp_rd(1'b1, a)));
      check($sformatf("%s rd%0d nozreg a=%0d", ctx, p, a), 64'(rd_data_nz[p*DW +: DW]), 64'(exp_rd(1'b0, a)));
    end
    check({ctx, " ready zreg"}, 64'(ready_z), 64'(ref_ready));
    check({ctx, " ready nozreg"}, 64'(ready_nz), 64'(ref_ready));
    check({ctx, " wr_drop zreg"}, 64'(drop_z), 64'(ref_drop));
    check({ctx, " wr_drop nozreg"}, 64'(drop_nz), 64'(ref_drop));
  endtask

  // One clock: combinational check before the edge, model update, registered check after it.
  task automatic step(input string ctx);
    #1 check_all({ctx, " pre"});
    @(posedge clk);
    model_edge();
    #1 check_all({ctx, " post"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;

    @(posedge clk);
    model_edge();
    #1 check_all("reset");
    step("reset2");

    // Release and clear; a write at clear cycle 10 must be dropped.
    rst = 1'b0;
    n   = 0;
    while (!ready_z && n < 100) begin
      if (n == 10) begin
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_5678;
      end else begin
        wr_en = 1'b0;
      end
      step("clear");
      if (n == 10) check("drop pulse high", 64'(drop_z), 64'd1);
      if (n == 11) check("drop pulse low", 64'(drop_z), 64'd0);
      n++;
    end
    check("clear length", 64'(n), 64'd32);
    wr_en = 1'b0;

    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = {AW'(DEPTH - 1 - a), AW'(a)};
      step("sweep");
    end
    rd_addr = {5'd5, 5'd5};
    #1 check("addr5 after drop", 64'(rd_data_z), 64'd0);

    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hFFFF_FFFF; rd_addr = {5'd1, 5'd1};
    step("wr1");
    wr_en = 1'b0;
    step("rd1");
    check("all ones both ports", 64'(rd_data_z), {2{32'hFFFF_FFFF}});

    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEAD_BEEF; rd_addr = {5'd0, 5'd0};
    step("wr0");
    wr_en = 1'b0;
    step("rd0");
    check("zero reg reads 0", 64'(rd_data_z), 64'd0);
    check("no zero reg reads value", 64'(rd_data_nz), {2{32'hDEAD_BEEF}});
    check("zero reg write no drop", 64'(drop_z), 64'd0);

    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5; rd_addr = {5'd7, 5'd1};
`ifdef REGFILE_BYPASS_EN
    #1 check("bypass port1", 64'(rd_data_z[DW +: DW]), 64'hA5A5_A5A5);
`else
    #1 check("no bypass port1", 64'(rd_data_z[DW +: DW]), 64'd0);
`endif
    step("bypass");
    wr_en = 1'b0;
    step("after bypass");
    check("addr7 stored", 64'(rd_data_z[DW +: DW]), 64'hA5A5_A5A5);

    // Reset reasserted mid-clear restarts the full sequence.
    rst = 1'b1;
    step("rst again");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step("clear part");
    rst = 1'b1;
    step("mid rst");
    rst = 1'b0;
    n   = 0;
    while (!ready_z && n < 100) begin
      step("reclear");
      n++;
    end
    check("reclear length", 64'(n), 64'd32);
    rd_addr = {5'd7, 5'd1};
    #1 check("cleared after reclear", 64'(rd_data_nz), 64'd0);

    for (int i = 0; i < 400; i++) begin
      wr_en   = 1'($urandom);
      wr_addr = AW'($urandom);
      wr_data = $urandom;
      rd_addr = RW'($urandom);
      if ($urandom_range(0, 3) == 0) rd_addr[AW +: AW] = wr_addr;
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
